// File: rtl/mem_trace_buf_pkg.sv
// Shared types and sizing helpers for the memory-bus trace buffer.
// TRACE_TIMESTAMP_EN widens every entry by a TS_W-bit timestamp in the MSBs.
package trace_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        POST  = 3'd2,
        DONE  = 3'd3,
        DUMP  = 3'd4
    } trace_state_e;

    localparam int TS_W = 16;

`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_FIELD_W = TS_W;
`else
    localparam int TS_FIELD_W = 0;
`endif

    // Entry layout, MSB first: {[timestamp,] wr, byte_en[3:0], addr, data}
    function automatic int entry_width(input int addr_w, input int data_w);
        return TS_FIELD_W + 1 + 4 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/mem_trace_buf_if.sv
// Tap (memory-bus sample) and dump-stream signals of the trace buffer.
// master = trace unit side, slave = core tap / dump consumer side.
interface mem_trace_buf_if
    import trace_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DUMP_W = entry_width(ADDR_W, DATA_W)
);
    logic [ADDR_W-1:0] tap_addr1;
    logic [DATA_W-1:0] tap_rd_data1;
    logic              tap_wr_en;
    logic [ADDR_W-1:0] tap_wr_addr;
    logic [DATA_W-1:0] tap_wr_data;
    logic [3:0]        tap_byte_en;

    logic              dump_valid;
    logic              dump_ready;
    logic [DUMP_W-1:0] dump_data;
    logic              dump_last;

    modport master (
        input  tap_addr1, tap_rd_data1, tap_wr_en, tap_wr_addr, tap_wr_data, tap_byte_en,
        input  dump_ready,
        output dump_valid, dump_data, dump_last
    );

    modport slave (
        output tap_addr1, tap_rd_data1, tap_wr_en, tap_wr_addr, tap_wr_data, tap_byte_en,
        output dump_ready,
        input  dump_valid, dump_data, dump_last
    );
endinterface

// File: rtl/mem_trace_buf_ram.sv
// Simple dual-port trace storage: synchronous write, registered read (1-cycle latency).
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 69
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end
endmodule

// File: rtl/mem_trace_buf.sv
// Memory-bus trace capture: circular buffer with address trigger and oldest-first dump.
// Optional TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp to every entry.
module mem_trace_buf
    import trace_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 64,
    parameter int POST_DEPTH   = 16,
    parameter int CAPTURE_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_trace_buf_if.master          bus,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [ADDR_W-1:0]        trig_addr,
    input  logic [ADDR_W-1:0]        trig_mask,
    input  logic                     dump_start,
    output logic [2:0]               trace_state,
    output logic [$clog2(DEPTH):0]   trace_count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BASE_W  = 1 + 4 + ADDR_W + DATA_W;
    localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);

    trace_state_e       state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   post_cnt_q, post_cnt_d;

    logic [PTR_W-1:0]   rd_slot_q, rd_slot_d, rd_slot_cur, start_slot;
    logic [CNT_W-1:0]   rem_q, rem_d, rem_cur;
    logic               rd_pend_q, rd_pend_d, rd_last_q, rd_last_d;
    logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [ENTRY_W-1:0] out_data_q, out_data_d;
    logic               skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
    logic [ENTRY_W-1:0] skid_data_q, skid_data_d;

    logic               qualify, trig_hit, cap_en, arm_go, dump_go, dump_finish;
    logic               pop, issue;
    logic [1:0]         occ;
    logic [BASE_W-1:0]  base_entry;
    logic [ENTRY_W-1:0] cap_entry, ram_rd_data;

    assign qualify  = (CAPTURE_MODE != 0) || bus.tap_wr_en;
    assign trig_hit = bus.tap_wr_en && (((bus.tap_wr_addr ^ trig_addr) & trig_mask) == '0);

    always_comb begin
        base_entry = {1'b0, 4'b0000, bus.tap_addr1, bus.tap_rd_data1};
        if (bus.tap_wr_en) begin
            base_entry = {1'b1, bus.tap_byte_en, bus.tap_wr_addr, bus.tap_wr_data};
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else if (arm_go) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign cap_entry = {ts_q, base_entry};
`else
    assign cap_entry = base_entry;
`endif

    // Capture/trigger FSM; abort overrides every other event, including capture.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        fill_d     = fill_q;
        post_cnt_d = post_cnt_q;
        cap_en     = 1'b0;
        arm_go     = 1'b0;
        dump_go    = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d = ARMED;
                        ptr_d   = '0;
                        fill_d  = '0;
                        arm_go  = 1'b1;
                    end
                end
                ARMED: begin
                    if (qualify) begin
                        cap_en = 1'b1;
                        if (trig_hit) begin
                            post_cnt_d = '0;
                            state_d    = (POST_DEPTH == 0) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    if (qualify) begin
                        cap_en     = 1'b1;
                        post_cnt_d = post_cnt_q + 1'b1;
                        if (post_cnt_q + 1'b1 == CNT_W'(POST_DEPTH)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (dump_start) begin
                        state_d = DUMP;
                        dump_go = 1'b1;
                    end
                end
                DUMP: begin
                    if (dump_finish) begin
                        state_d = IDLE;
                        fill_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (cap_en) begin
                ptr_d = ptr_q + 1'b1;
                if (fill_q != CNT_W'(DEPTH)) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
    end

    // Readout: RAM read -> (skid) -> output register. A read is issued only when
    // out + skid + in-flight stays within two, so a stalled consumer never drops data.
    assign start_slot  = (fill_q == CNT_W'(DEPTH)) ? ptr_q : '0;
    assign rd_slot_cur = (state_q == DUMP) ? rd_slot_q : start_slot;
    assign rem_cur     = (state_q == DUMP) ? rem_q : fill_q;
    assign pop         = out_valid_q && bus.dump_ready;
    assign occ         = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
    assign issue       = !abort && ((state_q == DUMP) || dump_go) && (rem_cur != '0)
                         && ((occ < 2'd2) || pop);
    assign dump_finish = (pop && out_last_q)
                         || ((rem_q == '0) && (occ == 2'd0));

    always_comb begin
        rd_slot_d    = rd_slot_q;
        rem_d        = rem_q;
        rd_pend_d    = issue;
        rd_last_d    = issue && (rem_cur == CNT_W'(1));
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;
        if (issue) begin
            rd_slot_d = rd_slot_cur + 1'b1;
            rem_d     = rem_cur - 1'b1;
        end
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_last_d   = skid_last_q;
                out_data_d   = skid_data_q;
                skid_valid_d = rd_pend_q;
                skid_last_d  = rd_last_q;
                skid_data_d  = rd_pend_q ? ram_rd_data : skid_data_q;
            end else if (rd_pend_q) begin
                out_valid_d = 1'b1;
                out_last_d  = rd_last_q;
                out_data_d  = ram_rd_data;
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end else if (rd_pend_q) begin
            skid_valid_d = 1'b1;
            skid_last_d  = rd_last_q;
            skid_data_d  = ram_rd_data;
        end
        if (abort) begin
            rd_pend_d    = 1'b0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            fill_q       <= '0;
            post_cnt_q   <= '0;
            rd_slot_q    <= '0;
            rem_q        <= '0;
            rd_pend_q    <= 1'b0;
            rd_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            fill_q       <= fill_d;
            post_cnt_q   <= post_cnt_d;
            rd_slot_q    <= rd_slot_d;
            rem_q        <= rem_d;
            rd_pend_q    <= rd_pend_d;
            rd_last_q    <= rd_last_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (cap_en),
        .wr_addr_i (ptr_q),
        .wr_data_i (cap_entry),
        .rd_en_i   (issue),
        .rd_addr_i (rd_slot_cur),
        .rd_data_o (ram_rd_data)
    );

    assign bus.dump_valid = out_valid_q;
    assign bus.dump_data  = out_data_q;
    assign bus.dump_last  = out_last_q;
    assign trace_state    = state_q;
    assign trace_count    = fill_q;

endmodule

// File: tb/tb_mem_trace_buf.sv
// Self-checking bench for mem_trace_buf: a mode-0 and a mode-1 instance share all stimulus.
module tb_mem_trace_buf;
    import trace_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int POST  = 2;
    localparam int EW    = entry_width(AW, DW);
    localparam int BW    = 1 + 4 + AW + DW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          arm = 1'b0, abort = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
    logic [AW-1:0] trig_addr = 32'h104;
    logic [AW-1:0] trig_mask = 32'hFFFF_FFFF;
    logic [AW-1:0] addr1 = '0, wr_addr = '0;
    logic [DW-1:0] rd1 = '0, wr_data = '0;
    logic          wr_en = 1'b0;
    logic [3:0]    be = '0;
    logic [2:0]    st0, st1;
    logic [3:0]    cnt0, cnt1;

    mem_trace_buf_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
    mem_trace_buf_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    assign if0.tap_addr1 = addr1;   assign if1.tap_addr1 = addr1;
    assign if0.tap_rd_data1 = rd1;  assign if1.tap_rd_data1 = rd1;
    assign if0.tap_wr_en = wr_en;   assign if1.tap_wr_en = wr_en;
    assign if0.tap_wr_addr = wr_addr; assign if1.tap_wr_addr = wr_addr;
    assign if0.tap_wr_data = wr_data; assign if1.tap_wr_data = wr_data;
    assign if0.tap_byte_en = be;    assign if1.tap_byte_en = be;
    assign if0.dump_ready = dump_ready; assign if1.dump_ready = dump_ready;

    mem_trace_buf #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .POST_DEPTH(POST), .CAPTURE_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.master), .arm(arm), .abort(abort),
        .trig_addr(trig_addr), .trig_mask(trig_mask), .dump_start(dump_start),
        .trace_state(st0), .trace_count(cnt0));

    mem_trace_buf #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .POST_DEPTH(POST), .CAPTURE_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master), .arm(arm), .abort(abort),
        .trig_addr(trig_addr), .trig_mask(trig_mask), .dump_start(dump_start),
        .trace_state(st1), .trace_count(cnt1));

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    be;
        bit            cap;
        logic [2:0]    st;
    } vec_t;

    vec_t          vecs[$];
    logic [BW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [BW-1:0] mk_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
        return {1'b1, b, a, d};
    endfunction

    function automatic logic [BW-1:0] mk_rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {1'b0, 4'b0000, a, d};
    endfunction

    function automatic vec_t mk_vec(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b,
                                    input bit cap, input logic [2:0] st);
        vec_t v;
        v.addr = a; v.data = d; v.be = b; v.cap = cap; v.st = st;
        return v;
    endfunction

    task automatic load_basic();
        vecs.delete();
        vecs.push_back(mk_vec(32'h100, 32'h11, 4'hF, 1'b1, 3'd1));
        vecs.push_back(mk_vec(32'h104, 32'h22, 4'h3, 1'b1, 3'd2));
        vecs.push_back(mk_vec(32'h108, 32'h33, 4'h5, 1'b1, 3'd2));
        vecs.push_back(mk_vec(32'h10C, 32'h44, 4'h8, 1'b1, 3'd3));
        vecs.push_back(mk_vec(32'h110, 32'h55, 4'hF, 1'b0, 3'd3));
    endtask

    task automatic do_arm();
        exp_q.delete();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("arm_state", st0, 3'd1);
        check("arm_count", cnt0, 0);
    endtask

    // Back-to-back writes from the vector table; expected buffer keeps the newest DEPTH entries.
    task automatic apply_vecs();
        foreach (vecs[i]) begin
            wr_en = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data; be = vecs[i].be;
            @(negedge clk);
            if (vecs[i].cap) begin
                exp_q.push_back(mk_wr(vecs[i].addr, vecs[i].data, vecs[i].be));
                if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            end
            check($sformatf("vec%0d_state", i), st0, vecs[i].st);
            check($sformatf("vec%0d_count", i), cnt0, exp_q.size());
        end
        wr_en = 1'b0; be = '0;
    endtask

    task automatic do_dump(input bit sel, input bit toggle, input int abort_beat);
        int n_exp = exp_q.size();
        int beats = 0;
        int cyc = 0;
        bit seen = 1'b0;
        bit stalled = 1'b0;
        logic v, l, held_l;
        logic [EW-1:0] d, held;
        logic [BW-1:0] e;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        while (beats < n_exp && cyc < 64) begin
            v = sel ? if1.dump_valid : if0.dump_valid;
            l = sel ? if1.dump_last : if0.dump_last;
            d = sel ? if1.dump_data : if0.dump_data;
            dump_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (v && !seen) begin
                seen = 1'b1;
                check("first_valid_latency", cyc <= 1, 1'b1);
            end
            if (stalled) begin
                check("stall_valid", v, 1'b1);
                check("stall_data", d, held);
                check("stall_last", l, held_l);
            end
            if (v && dump_ready) begin
                e = exp_q.pop_front();
                $display("beat %0d: data=%h last=%0b", beats, d[BW-1:0], l);
                check($sformatf("beat%0d_data", beats), d[BW-1:0], e);
                check($sformatf("beat%0d_last", beats), l, exp_q.size() == 0);
                beats++;
                stalled = 1'b0;
                if (beats == abort_beat) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    dump_ready = 1'b0;
                    check("abort_valid", sel ? if1.dump_valid : if0.dump_valid, 1'b0);
                    check("abort_state", sel ? st1 : st0, 3'd0);
                    exp_q.delete();
                    return;
                end
            end else if (v) begin
                stalled = 1'b1; held = d; held_l = l;
            end
            @(negedge clk);
            cyc++;
        end
        dump_ready = 1'b0;
        check("dump_beats", beats, n_exp);
        check("post_dump_valid", sel ? if1.dump_valid : if0.dump_valid, 1'b0);
        check("post_dump_state", sel ? st1 : st0, 3'd0);
        check("post_dump_count", sel ? cnt1 : cnt0, 0);
    endtask

    initial begin
        // 1: reset with tap activity
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en = i[0]; wr_addr = 32'h104; wr_data = 32'(i); be = 4'hF; arm = 1'b1;
        end
        @(negedge clk);
        check("rst_valid", if0.dump_valid, 1'b0);
        check("rst_last", if0.dump_last, 1'b0);
        check("rst_data", if0.dump_data, 0);
        check("rst_state", st0, 3'd0);
        check("rst_count", cnt0, 0);
        arm = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; be = '0;
        check("rst_rel_state", st0, 3'd0);
        check("rst_rel_count", cnt0, 0);

        // 2: basic trigger
        load_basic();
        do_arm();
        apply_vecs();
        do_dump(1'b0, 1'b0, 0);

        // 4: backpressure
        do_arm();
        apply_vecs();
        do_dump(1'b0, 1'b1, 0);

        // 3: wrap
        trig_addr = 32'h200;
        vecs.delete();
        for (int i = 0; i < 12; i++) vecs.push_back(mk_vec(32'(i * 4), 32'(i + 1), 4'hF, 1'b1, 3'd1));
        vecs.push_back(mk_vec(32'h200, 32'hA0, 4'h1, 1'b1, 3'd2));
        vecs.push_back(mk_vec(32'h204, 32'hA1, 4'h2, 1'b1, 3'd2));
        vecs.push_back(mk_vec(32'h208, 32'hA2, 4'h4, 1'b1, 3'd3));
        do_arm();
        apply_vecs();
        check("wrap_count", cnt0, 8);
        do_dump(1'b0, 1'b0, 0);
        trig_addr = 32'h104;

        // 5: abort on second beat; fill kept until the next arm
        load_basic();
        do_arm();
        apply_vecs();
        do_dump(1'b0, 1'b0, 2);
        check("abort_fill_kept", cnt0, 4);
        do_arm();

        // 6: mode 1 read capture
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("m1_idle", st1, 3'd0);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        exp_q.delete();
        check("m1_armed", st1, 3'd1);
        addr1 = 32'h40; rd1 = 32'hDEAD;
        @(negedge clk);
        exp_q.push_back(mk_rd(32'h40, 32'hDEAD));
        check("m1_count_read", cnt1, 1);
        wr_en = 1'b1; wr_addr = 32'h104; wr_data = 32'h99; be = 4'hF;
        @(negedge clk);
        exp_q.push_back(mk_wr(32'h104, 32'h99, 4'hF));
        wr_en = 1'b0; be = '0;
        check("m1_post", st1, 3'd2);
        check("m0_post", st0, 3'd2);
        addr1 = 32'h44; rd1 = 32'h1;
        @(negedge clk);
        exp_q.push_back(mk_rd(32'h44, 32'h1));
        addr1 = 32'h48; rd1 = 32'h2;
        @(negedge clk);
        exp_q.push_back(mk_rd(32'h48, 32'h2));
        addr1 = '0; rd1 = '0;
        check("m1_done", st1, 3'd3);
        check("m1_count", cnt1, 4);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("arm_ignored_state", st1, 3'd3);
        check("arm_ignored_count", cnt1, 4);
        do_dump(1'b1, 1'b0, 0);
        check("dump_start_ignored", st0, 3'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_trace_buf.md
Name: mem_trace_buf

Overview:
Parametrised memory-bus trace capture unit, generalising the fixed debug_mem_* tap outputs of the top-level integration.
- Sits beside the core/memory pair, passively sampling the memory interface.
- Records qualifying transactions into a circular buffer and stops a programmable number of entries after an address-match trigger.
- Streams the captured window out oldest-first over a valid/ready port.

Parameters:
ADDR_W, 32, tap address width
DATA_W, 32, tap data width
DEPTH, 64, buffer entries; power of two, >= 4
POST_DEPTH, 16, entries captured after the trigger entry; 0 <= POST_DEPTH < DEPTH
CAPTURE_MODE, 0, 0 = capture writes only; 1 = capture every cycle (write if tap_wr_en, else port-1 read)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tap_addr1  in  ADDR_W  read port-1 address
tap_rd_data1  in  DATA_W  read port-1 data
tap_wr_en  in  1  write enable
tap_wr_addr  in  ADDR_W  write address
tap_wr_data  in  DATA_W  write data
tap_byte_en  in  4  write byte enables
arm  in  1  start capture (honoured in IDLE only)
abort  in  1  return to IDLE from any state
trig_addr  in  ADDR_W  trigger compare address
trig_mask  in  ADDR_W  trigger compare mask; 1 = bit compared
dump_start  in  1  begin readout (honoured in DONE only)
dump_valid  out  1  dump beat valid
dump_ready  in  1  dump beat accepted
dump_data  out  1+4+ADDR_W+DATA_W  entry {wr, byte_en, addr, data}
dump_last  out  1  final beat of dump
trace_state  out  3  current FSM state encoding
trace_count  out  $clog2(DEPTH)+1  valid entries held

Behaviour:
- Reset: state IDLE; write pointer 0; fill 0; dump_valid 0; dump_last 0; dump_data 0; trace_state IDLE; trace_count 0.
- Qualifying cycle:
  - Mode 0: tap_wr_en=1.
  - Mode 1: every cycle.
- Entry contents:
  - Write: {1, tap_byte_en, tap_wr_addr, tap_wr_data}.
  - Read (mode 1, tap_wr_en=0): {0, 4'b0, tap_addr1, tap_rd_data1}.
  - Write takes priority.
- Trigger match: tap_wr_en=1 and ((tap_wr_addr ^ trig_addr) & trig_mask)==0.
- FSM:
  - IDLE: arm -> ARMED; clears pointer and fill.
  - ARMED: captures each qualifying cycle into slot ptr; ptr wraps mod DEPTH; fill saturates at DEPTH. On match, the trigger entry is captured that cycle, then -> POST (or -> DONE if POST_DEPTH=0).
  - POST: captures qualifying cycles; further matches ignored. After POST_DEPTH captures -> DONE.
  - DONE: capture frozen. dump_start -> DUMP.
  - DUMP:
    - Emits trace_count beats.
    - Start slot: 0 if fill<DEPTH, else ptr (oldest first).
    - dump_last asserts with the final beat.
    - After final accepted beat -> IDLE with fill cleared.
- Dump handshake:
  - First dump_valid within 2 cycles of dump_start.
  - Beat transfers when dump_valid & dump_ready.
  - dump_data and dump_last are held stable while dump_valid=1 and dump_ready=0.
  - Throughput is 1 beat/cycle with dump_ready held high.
  - No beat may be lost or duplicated.
- Simultaneous events:
  - abort beats all others: next cycle IDLE, dump_valid=0, fill kept until next arm.
  - arm outside IDLE is ignored.
  - dump_start outside DONE is ignored.
  - Trigger on the same cycle as arm is not recognised; capture starts the cycle after arm.
- trace_count reflects fill, registered, updated the cycle after a capture.

Optional Feature:
TRACE_TIMESTAMP_EN
- Defined:
  - Free-running 16-bit cycle counter, cleared on arm, wrapping at 0xFFFF.
  - Each entry gains a 16-bit timestamp MSB field.
  - dump_data width becomes 17+4+ADDR_W+DATA_W.
- Undefined: no counter, no field; width as listed.

Decomposition:
- trace_pkg holds:
  - state enum: IDLE, ARMED, POST, DONE, DUMP.
  - Parametrised entry struct or width function.
  - Timestamp width constant TS_W=16.
- One sub-module, trace_ram: simple dual-port RAM, DEPTH x entry width.
  - Synchronous write port.
  - Registered read port with 1-cycle latency.
- The FSM and dump skid logic live in mem_trace_buf.

Test Plan:
Common configuration for all scenarios: DEPTH=8, POST_DEPTH=2, mode 0 unless stated; trig_addr=0x104, trig_mask=0xFFFFFFFF unless stated.
1. Reset with tap activity -> all outputs 0, trace_state=IDLE, trace_count=0.
2. Basic trigger:
   - Stimulus: arm; writes 0x100/0x11, 0x104/0x22, 0x108/0x33, 0x10C/0x44, 0x110/0x55; dump with ready=1.
   - Response: DONE after 0x10C; 4 beats 0x100..0x10C, each with data and byte_en; dump_last on beat 4; 0x110 not captured.
3. Wrap:
   - Stimulus: trig_addr=0x200; arm; 12 writes to 0x00..0x2C, then 0x200, 0x204, 0x208; dump.
   - Response: 8 beats 0x1C, 0x20, 0x24, 0x28, 0x2C, 0x200, 0x204, 0x208; trace_count=8.
4. Backpressure: repeat scenario 2 with dump_ready toggling 1010... -> identical 4-beat sequence; data stable on stalled cycles.
5. Abort: abort on the second dump beat -> next cycle dump_valid=0, trace_state=IDLE; a following arm clears trace_count to 0.
6. Mode 1:
   - Stimulus: CAPTURE_MODE=1; read cycle addr1=0x40, rd_data1=0xDEAD; then trigger write.
   - Response: the read entry dumps as {0, 4'b0, 0x40, 0xDEAD}.
